// File: rtl/muldiv_scoreboard.sv
// muldiv_scoreboard: sequences the multi-cycle MUL/DIV unit beside EX,
// tracks its single outstanding op, raises stalls, arbitrates RF write.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   longopD, rs1D, rs2D,
//   rdD, writesregD     instruction currently in D
//   longopE, isdivE,
//   rdE                 mul/div issuing from E this cycle
//   writesregW          pipeline W stage owns the RF write port
//   md_start            one-cycle start pulse to the MUL/DIV unit
//   md_busy             a long op is outstanding
//   wb_grant, wb_rd     long-op result writes the RF this cycle
//   stallF_md,
//   stallD_md,
//   flushE_md           front-end freeze / E bubble (all equal)

module muldiv_scoreboard #(
   parameter int MUL_LAT  = 3,
   parameter int DIV_LAT  = 16,
   parameter int WAIT_MAX = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       longopD,
   input  logic [4:0] rs1D,
   input  logic [4:0] rs2D,
   input  logic [4:0] rdD,
   input  logic       writesregD,
   input  logic       longopE,
   input  logic       isdivE,
   input  logic [4:0] rdE,
   input  logic       writesregW,
   output logic       md_start,
   output logic       md_busy,
   output logic       wb_grant,
   output logic [4:0] wb_rd,
   output logic       stallF_md,
   output logic       stallD_md,
   output logic       flushE_md
);

   localparam int MAX_LAT =
      (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW =
      (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam int WW =
      (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

   localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_INIT = CW'(DIV_LAT - 1);
   localparam logic [WW-1:0] WAIT_TOP = WW'(WAIT_MAX);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] WBWAIT = 2'd2;

   logic [1:0]    state;
   logic [4:0]    pendRd;
   logic [CW-1:0] cnt;
   logic [WW-1:0] waitCnt;

   logic active;
   logic inWb;
   logic structHaz;
   logic rawPend;
   logic rawIssue;
   logic wawHaz;
   logic starve;
   logic stall;

   assign active   = (state != IDLE);
   assign inWb     = (state == WBWAIT);
   assign md_busy  = active;
   assign wb_grant = inWb && !writesregW;
   assign wb_rd    = inWb ? pendRd : 5'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         pendRd   <= '0;
         cnt      <= '0;
         waitCnt  <= '0;
         md_start <= 1'b0;
      end else begin
         md_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (longopE) begin
                  pendRd   <= rdE;
                  cnt      <= isdivE ? DIV_INIT
                                     : MUL_INIT;
                  state    <= BUSY;
                  md_start <= 1'b1;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  // an x0 result has nowhere to go
                  state <= (pendRd != 5'd0) ? WBWAIT
                                            : IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WBWAIT: begin
               if (wb_grant) begin
                  state   <= IDLE;
                  waitCnt <= '0;
               end else if (waitCnt != WAIT_TOP) begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign structHaz = longopD && (active || longopE);

   assign rawPend = active && (pendRd != 5'd0) &&
                    ((rs1D == pendRd) ||
                     (rs2D == pendRd));

   assign rawIssue = longopE && (rdE != 5'd0) &&
                     ((rs1D == rdE) || (rs2D == rdE));

   assign wawHaz = writesregD && (rdD != 5'd0) &&
                   ((active && (rdD == pendRd)) ||
                    (longopE && (rdD == rdE)));

   // the finished result has been refused too long:
   // freeze the front end so W frees the port
   assign starve = inWb && (waitCnt == WAIT_TOP);

   // held low in reset so every output reads 0
   assign stall = rst_n &&
                  (structHaz || rawPend || rawIssue ||
                   wawHaz || starve);

   assign stallF_md = stall;
   assign stallD_md = stall;
   assign flushE_md = stall;

endmodule
